// File: rtl/vad_pkg.sv
// rtl/vad_pkg.sv - shared constants, state type and helpers for the voice activity detector
package vad_pkg;

    localparam int HANG_N    = 300 * 16000 / 1000;
    localparam int BUF_N     = 1500 * 16000 / 1000;
    localparam int FRAME_LEN = 160;
    localparam int ZCR_MIN   = 48;
    localparam int FRAME_W   = $clog2(FRAME_LEN);
    localparam int ZC_W      = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        SILENCE = 1'b0,
        SPEECH  = 1'b1
    } vad_state_t;

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vad_frame_stats.sv
// rtl/vad_frame_stats.sv - per-frame noise-floor minimum and zero-crossing statistics
module vad_frame_stats
    import vad_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_valid,
    input  logic            sample_sign,
    input  logic [31:0]     energy,
    output logic [31:0]     noise_floor,
    output logic [ZC_W-1:0] zcr_last
);

    logic [FRAME_W-1:0] frame_cnt;
    logic [31:0]        frame_min;
    logic [31:0]        cur_min;
    logic [ZC_W-1:0]    zc;
    logic [ZC_W-1:0]    zc_total;
    logic               prev_sign;
    logic               crossing;
    logic               frame_end;
    logic [32:0]        nf_grown;
    logic [31:0]        nf_next;

    always_comb begin
        frame_end = (frame_cnt == FRAME_W'(FRAME_LEN - 1));
        crossing  = sample_sign ^ prev_sign;
        cur_min   = (frame_cnt == '0) ? energy : min32(frame_min, energy);
        zc_total  = zc + ZC_W'(crossing);
        // Floor may creep up by ~1.6% per frame; 33 bits keep the all-ones reset value from wrapping.
        nf_grown  = {1'b0, noise_floor} + {7'b0, noise_floor[31:6]} + 33'd1;
        nf_next   = (nf_grown < {1'b0, cur_min}) ? nf_grown[31:0] : cur_min;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_min   <= '0;
            zc          <= '0;
            zcr_last    <= '0;
            prev_sign   <= 1'b0;
            noise_floor <= 32'hFFFF_FFFF;
        end else if (sample_valid) begin
            prev_sign <= sample_sign;
            frame_min <= cur_min;
            if (frame_end) begin
                frame_cnt   <= '0;
                noise_floor <= nf_next;
                zcr_last    <= zc_total;
                zc          <= '0;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
                zc        <= zc_total;
            end
        end
    end

endmodule

// File: rtl/voice_activity_detector.sv
// rtl/voice_activity_detector.sv - energy VAD with hysteresis, hangover and capture gate
module voice_activity_detector
    import vad_pkg::*;
#(
    parameter int          SAMPLE_RATE    = 16000,
    parameter logic [31:0] THRESHOLD      = 32'd1_000_000,
    parameter int          HANGOVER_MS    = 300,
    parameter int          BUFFER_SIZE_MS = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] audio_in,
    input  logic        sample_valid,
    output logic        speech_detected,
    output logic [31:0] smoothed_energy,
    output logic        recording_active
);

    localparam int          HANG_LEN = HANGOVER_MS * SAMPLE_RATE / 1000;
    localparam int          BUF_LEN  = BUFFER_SIZE_MS * SAMPLE_RATE / 1000;
    localparam int          HANG_W   = $clog2(HANG_LEN + 1);
    localparam int          BUF_W    = $clog2(BUF_LEN + 1);
    localparam logic [31:0] REL_THR  = THRESHOLD >> 1;
    localparam logic [31:0] ZCR_THR  = THRESHOLD >> 2;

    vad_state_t         state;
    logic [HANG_W-1:0]  hang_cnt;
    logic [BUF_W-1:0]   rec_cnt;
    logic [31:0]        noise_floor;
    logic [ZC_W-1:0]    zcr_last;
    logic signed [31:0] sq_s;
    logic signed [32:0] diff;
    logic signed [32:0] step;
    logic [31:0]        energy_next;
    logic [31:0]        nf_sh;
    logic [31:0]        on_thr;
    logic               onset;

    vad_frame_stats u_frame_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_sign  (audio_in[15]),
        .energy       (smoothed_energy),
        .noise_floor  (noise_floor),
        .zcr_last     (zcr_last)
    );

    always_comb begin
        sq_s        = $signed(audio_in) * $signed(audio_in);
        diff        = $signed({1'b0, sq_s}) - $signed({1'b0, smoothed_energy});
        step        = diff >>> 4;
        energy_next = smoothed_energy + 32'(step);
        nf_sh       = (noise_floor[31:29] != 3'b000) ? 32'hFFFF_FFFF : {noise_floor[28:0], 3'b000};
        on_thr      = (nf_sh > THRESHOLD) ? nf_sh : THRESHOLD;
        // Decisions use the registered energy, so they trail the EMA by one sample.
        onset       = (smoothed_energy >= on_thr) ||
                      ((smoothed_energy >= ZCR_THR) && (zcr_last >= ZC_W'(ZCR_MIN)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= SILENCE;
            smoothed_energy  <= '0;
            hang_cnt         <= '0;
            rec_cnt          <= '0;
            recording_active <= 1'b0;
        end else if (sample_valid) begin
            smoothed_energy <= energy_next;
            if (rec_cnt != '0) begin
                rec_cnt <= rec_cnt - BUF_W'(1);
            end
            case (state)
                SILENCE: begin
                    if (onset) begin
                        state            <= SPEECH;
                        hang_cnt         <= HANG_W'(HANG_LEN);
                        rec_cnt          <= BUF_W'(BUF_LEN);
                        recording_active <= 1'b1;
                    end else if (rec_cnt == '0) begin
                        recording_active <= 1'b0;
                    end
                end
                SPEECH: begin
                    if (smoothed_energy >= REL_THR) begin
                        hang_cnt <= HANG_W'(HANG_LEN);
                    end else if (hang_cnt == '0) begin
                        state <= SILENCE;
                    end else begin
                        hang_cnt <= hang_cnt - HANG_W'(1);
                    end
                end
                default: state <= SILENCE;
            endcase
        end
    end

    assign speech_detected = (state == SPEECH);

endmodule

// File: tb/tb_voice_activity_detector.sv
// tb/tb_voice_activity_detector.sv - scoreboard bench for voice_activity_detector
module tb_voice_activity_detector;

    typedef struct {
        logic [31:0] e;
        bit          csp;
        bit          sp;
        bit          crec;
        bit          rec;
    } exp_t;

    localparam logic [15:0] P3K  = 16'd3000;
    localparam logic [15:0] N3K  = 16'hF448;
    localparam logic [15:0] P600 = 16'd600;
    localparam logic [15:0] N600 = 16'hFDA8;
    localparam logic [15:0] MINV = 16'h8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_in = '0;
    logic        sample_valid = 1'b0;
    logic        speech_detected;
    logic [31:0] smoothed_energy;
    logic        recording_active;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_entries = 0;
    int     sn = 0;
    longint em = 0;
    bit     mono_on = 1'b0;

    voice_activity_detector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .audio_in         (audio_in),
        .sample_valid     (sample_valid),
        .speech_detected  (speech_detected),
        .smoothed_energy  (smoothed_energy),
        .recording_active (recording_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (strobe %0d)", name, act, exp, sn);
        end
    endtask

    task automatic send(input logic [15:0] x, input bit csp, input bit sp, input bit crec, input bit rec);
        exp_t   it;
        longint xs;
        longint d;
        @(negedge clk);
        audio_in     = x;
        sample_valid = 1'b1;
        xs = longint'($signed(x));
        d  = xs * xs - em;
        if (d >= 0) em = em + d / 16;
        else        em = em - (-d + 15) / 16;
        sn++;
        it.e   = 32'(em);
        it.csp = csp;
        it.sp  = sp;
        it.crec = crec;
        it.rec = rec;
        sbq.push_back(it);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n = 1'b0;
        em = 0;
        #1;
        check("rst_speech", speech_detected, 0);
        check("rst_rec", recording_active, 0);
        check("rst_energy", smoothed_energy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one scoreboard entry per accepted strobe, plus per-strobe invariants.
    initial begin : monitor
        exp_t        it;
        logic [31:0] last_e;
        logic        prev_sp;
        last_e  = '0;
        prev_sp = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                last_e  = '0;
                prev_sp = 1'b0;
            end else if (sample_valid) begin
                #1;
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    it = sbq.pop_front();
                    check("energy", smoothed_energy, it.e);
                    if (it.csp) check("speech", speech_detected, it.sp);
                    if (it.crec) check("rec", recording_active, it.rec);
                end
                if (speech_detected) check("inv_rec_when_speech", recording_active, 1);
                check("energy_bit31", smoothed_energy[31], 0);
                if (mono_on) begin
                    check("energy_monotone", (smoothed_energy >= last_e) ? 1 : 0, 1);
                    check("energy_cap", (smoothed_energy <= 32'h4000_0000) ? 1 : 0, 1);
                end
                if (speech_detected && !prev_sp) n_entries++;
                prev_sp = speech_detected;
                last_e  = smoothed_energy;
            end
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     onset;
        int     kfall;
        int     i;
        int     ent0;
        bit     found;
        bit     sp_exp;
        logic [15:0] x;

        do_reset();

        // Quiet background noise: never speech, no capture.
        for (int j = 0; j < 8000; j++) begin
            x = 16'($urandom_range(29, 10));
            send(x, 1, 0, 1, 0);
        end
        idle(3);

        // Square wave onset: energy crosses the threshold after two samples, decision one later.
        onset = sn + 3;
        for (int j = 1; j <= 800; j++) begin
            x = ((((j - 1) / 40) % 2) == 0) ? P3K : N3K;
            send(x, 1, (j >= 3), 1, (j >= 3));
        end
        check("sq_energy_near_9e6", (em >= 64'd8_900_000 && em <= 64'd9_000_000) ? 1 : 0, 1);

        // Silence: hangover holds 4800 samples past the release point, capture runs 24000 from onset.
        found = 1'b0;
        kfall = 0;
        i     = 0;
        while (sn < onset + 24010) begin
            i++;
            x = 16'($urandom_range(19, 5));
            sp_exp = !(found && (i >= kfall));
            send(x, 1, sp_exp, 1, ((sn + 1) <= (onset + 24000)));
            if (!found && em < 64'd500_000) begin
                found = 1'b1;
                kfall = i + 4801;
            end
        end
        idle(3);

        // Bursts bridged by the hangover: exactly one speech entry.
        do_reset();
        for (int j = 0; j < 320; j++) send(16'd10, 1, 0, 1, 0);
        ent0 = n_entries;
        for (int b = 0; b < 10; b++) begin
            for (int j = 1; j <= 800; j++) begin
                send(P3K, 1, (b > 0 || j >= 3), 1, (b > 0 || j >= 3));
            end
            if (b < 9) begin
                for (int j = 0; j < 320; j++) send(16'd10, 1, 1, 1, 1);
            end
        end
        idle(1);
        check("burst_entries", n_entries - ent0, 1);

        // Reset while in speech, then full-scale negative input from a clean frame.
        do_reset();
        mono_on = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            send(MINV, 1, (j >= 161), 1, (j >= 161));
        end
        idle(2);
        mono_on = 1'b0;

        // Zero-crossing assist: ~40 crossings per frame is not enough, ~159 is.
        do_reset();
        for (int j = 1; j <= 480; j++) begin
            x = ((((j - 1) / 4) % 2) == 0) ? P600 : N600;
            send(x, 1, 0, 1, 0);
        end
        for (int j = 481; j <= 700; j++) begin
            x = ((j % 2) == 1) ? P600 : N600;
            send(x, 1, (j >= 641), 1, (j >= 641));
        end
        idle(4);

        check("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
